fft_stage_sequencer: RTL
========================

# fft_stage_sequencer

Control sequencer for an in-place radix-2 decimation-in-time FFT built around the single shared `butterfly` datapath. On `start` it walks every stage and every butterfly of a 2^LOG2N-point transform held in a dual-port sample memory. For each butterfly it issues one read-address pair and one twiddle index. After a fixed pipeline latency it issues the matching write-back address pair. Between stages it drains the pipeline so the next stage never reads a location before it has been written. Input data is already in bit-reversed order in memory.

## Interface
- `LOG2N`, 3, log2 of transform length; N = 2^LOG2N, legal range 2..10
- `BF_LAT`, 2, cycles from `rd_en` to the matching `wr_en` (memory read plus butterfly plus any registers); legal range 1..7
- `clk`  in  1  sole clock, rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `start`  in  1  begin a transform; sampled only in IDLE
- `busy`  out  1  high from the first ISSUE cycle through the last DRAIN cycle
- `done`  out  1  one-cycle pulse after the final write-back
- `stage`  out  LOG2N-bit-clog  current stage index s, 0..LOG2N-1
- `rd_en`  out  1  read-pair valid this cycle
- `rd_addr_a`, `rd_addr_b`  out  LOG2N each  butterfly upper and lower operand addresses
- `tw_idx`  out  LOG2N-1  twiddle exponent k for W_N^k
- `wr_en`  out  1  write-back pair valid this cycle
- `wr_addr_a`, `wr_addr_b`  out  LOG2N each  destinations for out1 and out2

## Operation
- State machine:
  - IDLE to ISSUE on `start`.
  - ISSUE stays for N/2 cycles; butterfly counter k runs 0..N/2-1.
  - ISSUE to DRAIN after k = N/2-1.
  - DRAIN lasts exactly BF_LAT cycles. It then goes to ISSUE with s+1 and k=0, or to DONE if s = LOG2N-1.
  - DONE lasts 1 cycle, then returns to IDLE.
- Address rule for stage s and butterfly k:
  - half = 2^s, pos = k mod half, grp = k >> s
  - a = grp·2·half + pos, b = a + half
  - tw = pos << (LOG2N-1-s)
- `rd_en` = 1 exactly in ISSUE cycles; addresses and `tw_idx` are valid with it.
- Write path: a BF_LAT-deep shift register of {valid, a, b}.
  - `wr_en`/`wr_addr_*` equal the `rd_en`/`rd_addr_*` values of BF_LAT cycles earlier.
  - The shift register keeps shifting in DRAIN and DONE.
- `start` while not IDLE is ignored; no queuing.
- Async reset at any point:
  - All state returns to IDLE, s=0, k=0, shift register cleared.
  - A transform in progress is abandoned; no further `wr_en`.
- Reset values of outputs: `busy`, `done`, `rd_en`, `wr_en` are 0. All addresses, `stage` and `tw_idx` are 0.
- Address outputs hold their last value outside ISSUE, but only the values qualified by `rd_en`/`wr_en` carry meaning.

## Timing
- `start` is sampled high at edge 0. The first ISSUE cycle (`rd_en` = 1, k=0, s=0) follows edge 0.
- Each stage takes N/2 ISSUE cycles plus BF_LAT DRAIN cycles.
- `busy` is high for LOG2N·(N/2 + BF_LAT) cycles. `done` follows immediately for 1 cycle.
- The last write of stage s occurs in the last DRAIN cycle. The first read of stage s+1 occurs in the cycle after it, so the memory needs no read-during-write bypass.
- `done` and `wr_en` never overlap: the final write is in the cycle before `done`.
- Back-to-back: `start` held high re-launches the transform on the cycle after DONE, because that cycle is IDLE.

## Structure
- Shared package `fft_pkg` holds:
  - the state enum {IDLE, ISSUE, DRAIN, DONE}
  - localparams NPTS = 2^LOG2N and HALF = NPTS/2
  - the address and twiddle width helpers
- Sub-module `fft_addr_gen` is purely combinational: (s, k) → (a, b, tw). It is reusable by a future DIF variant.
- Top level contains the FSM, the s/k/drain counters and the write-delay shift register.

## Test plan
- LOG2N=3, BF_LAT=2, pulse `start`:
  - stage 0 reads (0,1),(2,3),(4,5),(6,7) with tw 0
  - stage 1 reads (0,2),(1,3),(4,6),(5,7) with tw 0,2,0,2
  - stage 2 reads (0,4),(1,5),(2,6),(3,7) with tw 0,1,2,3
  - `busy` high 18 cycles, `done` in cycle 19
- Same run: each `wr_addr` pair equals the `rd_addr` pair 2 cycles earlier. There are 12 `wr_en` pulses in total, and there is no stage-s+1 read before the last stage-s write.
- `start` pulsed again mid-stage 1 → ignored; sequence and `done` timing unchanged.
- `rst_n` asserted during stage 1 DRAIN → all outputs 0 immediately; after release, IDLE with no `wr_en`. A new `start` then runs the full 18-cycle sequence.
- LOG2N=2, BF_LAT=1:
  - reads (0,1),(2,3), then (0,2),(1,3) with tw 0,1
  - `busy` 6 cycles
- `start` held high continuously with LOG2N=3, BF_LAT=2 → `done` pulses every 20 cycles.

Source files
------------

// File: rtl/fft_pkg.sv
`default_nettype none
// ============================================================================
// fft_pkg
// Shared state encoding and sizing helpers for the radix-2 FFT sequencer.
// Revision: 1.0
// ============================================================================
package fft_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } fft_state_e;

  localparam int DEF_LOG2N = 3;
  localparam int NPTS      = 1 << DEF_LOG2N;
  localparam int HALF      = NPTS / 2;

  function automatic int npts(input int log2n);
    return 1 << log2n;
  endfunction

  function automatic int addr_w(input int log2n);
    return log2n;
  endfunction

  function automatic int tw_w(input int log2n);
    return log2n - 1;
  endfunction

  function automatic int stage_w(input int log2n);
    return (log2n < 2) ? 1 : $clog2(log2n);
  endfunction

endpackage
`default_nettype wire

// File: rtl/fft_addr_gen.sv
`default_nettype none
// ============================================================================
// fft_addr_gen
// Combinational DIT butterfly address/twiddle generator: (s, k) -> (a, b, tw).
// Revision: 1.0
// ============================================================================
module fft_addr_gen
  import fft_pkg::*;
#(
  parameter int LOG2N = 3
) (
  input  logic [stage_w(LOG2N)-1:0] i_s,
  input  logic [LOG2N-2:0]          i_k,
  output logic [LOG2N-1:0]          o_a,
  output logic [LOG2N-1:0]          o_b,
  output logic [LOG2N-2:0]          o_tw
);

  localparam int c_aw = addr_w(LOG2N);
  localparam int c_tw = tw_w(LOG2N);
  localparam int c_sw = stage_w(LOG2N);
  localparam logic [c_sw-1:0] c_s_max = c_sw'(LOG2N - 1);

  logic [c_tw-1:0] w_pos;
  logic [c_tw-1:0] w_grp;
  logic [c_aw-1:0] w_half;
  logic [c_aw-1:0] w_a;

  // At the last stage 1<<s overflows the twiddle width, which conveniently
  // leaves an all-ones mask (every k bit is a position bit).
  always_comb begin
    w_half = c_aw'(1) << i_s;
    w_pos  = i_k & ((c_tw'(1) << i_s) - c_tw'(1));
    w_grp  = i_k >> i_s;
    w_a    = (({1'b0, w_grp} << i_s) << 1) | {1'b0, w_pos};
  end

  assign o_a  = w_a;
  assign o_b  = w_a | w_half;
  assign o_tw = w_pos << (c_s_max - i_s);

endmodule
`default_nettype wire

// File: rtl/fft_stage_sequencer.sv
`default_nettype none
// ============================================================================
// fft_stage_sequencer
// Stage/butterfly walker for an in-place radix-2 DIT FFT with delayed write-back.
// Revision: 1.0
// ============================================================================
module fft_stage_sequencer
  import fft_pkg::*;
#(
  parameter int LOG2N  = 3,
  parameter int BF_LAT = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  output logic                      busy,
  output logic                      done,
  output logic [stage_w(LOG2N)-1:0] stage,
  output logic                      rd_en,
  output logic [LOG2N-1:0]          rd_addr_a,
  output logic [LOG2N-1:0]          rd_addr_b,
  output logic [LOG2N-2:0]          tw_idx,
  output logic                      wr_en,
  output logic [LOG2N-1:0]          wr_addr_a,
  output logic [LOG2N-1:0]          wr_addr_b
);

  localparam int c_aw   = addr_w(LOG2N);
  localparam int c_tw   = tw_w(LOG2N);
  localparam int c_sw   = stage_w(LOG2N);
  localparam int c_dw   = $clog2(BF_LAT + 1);
  localparam int c_half = npts(LOG2N) / 2;

  localparam logic [c_tw-1:0] c_k_last = c_tw'(c_half - 1);
  localparam logic [c_sw-1:0] c_s_last = c_sw'(LOG2N - 1);
  localparam logic [c_dw-1:0] c_d_last = c_dw'(BF_LAT - 1);

  fft_state_e      r_state, w_state_nxt;
  logic [c_sw-1:0] r_stage, w_stage_nxt;
  logic [c_tw-1:0] r_k, w_k_nxt;
  logic [c_dw-1:0] r_drain, w_drain_nxt;

  logic [c_aw-1:0] w_gen_a, w_gen_b;
  logic [c_tw-1:0] w_gen_tw;
  logic [c_aw-1:0] r_rd_a, r_rd_b;
  logic [c_tw-1:0] r_tw;
  logic            w_rd_en;

  logic [BF_LAT-1:0]           r_sr_v;
  logic [BF_LAT-1:0][c_aw-1:0] r_sr_a;
  logic [BF_LAT-1:0][c_aw-1:0] r_sr_b;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_stage <= '0;
      r_k     <= '0;
      r_drain <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_stage <= w_stage_nxt;
      r_k     <= w_k_nxt;
      r_drain <= w_drain_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_stage_nxt = r_stage;
    w_k_nxt     = r_k;
    w_drain_nxt = r_drain;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_state_nxt = ISSUE;
          w_stage_nxt = '0;
          w_k_nxt     = '0;
        end
      end
      ISSUE: begin
        if (r_k == c_k_last) begin
          w_state_nxt = DRAIN;
          w_drain_nxt = '0;
        end else begin
          w_k_nxt = r_k + c_tw'(1);
        end
      end
      DRAIN: begin
        if (r_drain == c_d_last) begin
          if (r_stage == c_s_last) begin
            w_state_nxt = DONE;
          end else begin
            w_state_nxt = ISSUE;
            w_stage_nxt = r_stage + c_sw'(1);
            w_k_nxt     = '0;
          end
        end else begin
          w_drain_nxt = r_drain + c_dw'(1);
        end
      end
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Addresses are computed from the next (s, k) and registered, so they are
  // aligned with rd_en, reset to zero, and hold outside ISSUE.
  fft_addr_gen #(
    .LOG2N (LOG2N)
  ) u_addr_gen (
    .i_s  (w_stage_nxt),
    .i_k  (w_k_nxt),
    .o_a  (w_gen_a),
    .o_b  (w_gen_b),
    .o_tw (w_gen_tw)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_a <= '0;
      r_rd_b <= '0;
      r_tw   <= '0;
    end else if (w_state_nxt == ISSUE) begin
      r_rd_a <= w_gen_a;
      r_rd_b <= w_gen_b;
      r_tw   <= w_gen_tw;
    end
  end

  assign w_rd_en = (r_state == ISSUE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sr_v <= '0;
      r_sr_a <= '0;
      r_sr_b <= '0;
    end else begin
      r_sr_v[0] <= w_rd_en;
      r_sr_a[0] <= r_rd_a;
      r_sr_b[0] <= r_rd_b;
      for (int i = 1; i < BF_LAT; i++) begin
        r_sr_v[i] <= r_sr_v[i-1];
        r_sr_a[i] <= r_sr_a[i-1];
        r_sr_b[i] <= r_sr_b[i-1];
      end
    end
  end

  assign busy      = (r_state == ISSUE) || (r_state == DRAIN);
  assign done      = (r_state == DONE);
  assign stage     = r_stage;
  assign rd_en     = w_rd_en;
  assign rd_addr_a = r_rd_a;
  assign rd_addr_b = r_rd_b;
  assign tw_idx    = r_tw;
  assign wr_en     = r_sr_v[BF_LAT-1];
  assign wr_addr_a = r_sr_a[BF_LAT-1];
  assign wr_addr_b = r_sr_b[BF_LAT-1];

endmodule
`default_nettype wire
